// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared constants and helpers for the Johnson counter
package johnson_pkg;

  localparam int JC_DEFAULT_WIDTH = 4;
  localparam int JC_MAX_WIDTH     = 32;
  localparam logic [0:JC_MAX_WIDTH-1] JC_RESET_STATE = '0;

  // Vectors are padded to JC_MAX_WIDTH; only bits [0:width-1] are meaningful.
  function automatic logic [0:JC_MAX_WIDTH-1] jc_next(
    input logic [0:JC_MAX_WIDTH-1] state,
    input int                      width
  );
    logic [0:JC_MAX_WIDTH-1] nxt;
    nxt    = '0;
    nxt[0] = ~state[width-1];
    for (int i = 1; i < JC_MAX_WIDTH; i++) begin
      if (i < width) nxt[i] = state[i-1];
    end
    return nxt;
  endfunction

  // A legal ring state has at most one boundary between adjacent unequal bits.
  function automatic logic jc_is_legal(
    input logic [0:JC_MAX_WIDTH-1] state,
    input int                      width
  );
    int edges;
    edges = 0;
    for (int i = 0; i < JC_MAX_WIDTH - 1; i++) begin
      if ((i < width - 1) && (state[i] != state[i+1])) edges++;
    end
    return (edges <= 1);
  endfunction

endpackage

// File: rtl/johnson_legal_chk.sv
// rtl/johnson_legal_chk.sv - flags whether a counter state lies on the legal Johnson ring
module johnson_legal_chk
  import johnson_pkg::*;
#(
  parameter int WIDTH = JC_DEFAULT_WIDTH
) (
  input  logic [0:WIDTH-1] state,
  output logic             legal
);

  logic [0:JC_MAX_WIDTH-1] state_wide;

  always_comb begin
    state_wide            = '0;
    state_wide[0:WIDTH-1] = state;
    legal                 = jc_is_legal(state_wide, WIDTH);
  end

endmodule

// File: rtl/johnson_counter.sv
// rtl/johnson_counter.sv - free-running Johnson counter; JOHNSON_SELF_CORRECT_EN adds illegal-state recovery
module johnson_counter
  import johnson_pkg::*;
#(
  parameter int WIDTH = JC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [0:WIDTH-1] counter
);

  logic [0:WIDTH-1] counter_q;
  logic [0:WIDTH-1] counter_d;
  logic             state_legal;

`ifdef JOHNSON_SELF_CORRECT_EN
  johnson_legal_chk #(.WIDTH(WIDTH)) u_legal_chk (
    .state (counter_q),
    .legal (state_legal)
  );
`else
  assign state_legal = 1'b1;
`endif

  // Twisted shift: bit 0 takes the inverse of the last bit.
  assign counter_d = {~counter_q[WIDTH-1], counter_q[0:WIDTH-2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= JC_RESET_STATE[0:WIDTH-1];
    end else if (!state_legal) begin
      counter_q <= JC_RESET_STATE[0:WIDTH-1];
    end else begin
      counter_q <= counter_d;
    end
  end

  assign counter = counter_q;

endmodule

// File: tb/tb_johnson_counter.sv
// tb/tb_johnson_counter.sv - self-checking bench for johnson_counter (WIDTH 4 and 5)
module tb_johnson_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [0:3] cnt4;
  logic [0:4] cnt5;

  int checks   = 0;
  int failures = 0;
  int since    = 0;
  bit track_en = 1'b0;

  logic [0:31] m4, m5;
  logic [0:3]  e4, prev4;
  logic [0:4]  e5, prev5;
  bit          prev_ok = 1'b0;

  logic [0:3] para [8];

  johnson_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .counter(cnt4));
  johnson_counter #(.WIDTH(5)) dut5 (.clk(clk), .reset(reset), .counter(cnt5));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) since <= 0;
    else       since <= since + 1;
  end

  // Step n of the ring: n ones filling from bit 0, then n-W zeros filling from bit 0.
  function automatic logic [0:31] model_state(input int w, input int n);
    logic [0:31] s;
    int k;
    s = '0;
    k = n % (2 * w);
    for (int i = 0; i < w; i++) s[i] = (k <= w) ? (i < k) : (i >= k - w);
    return s;
  endfunction

  always @(negedge clk) begin
    if (track_en && !reset) begin
      m4 = model_state(4, since);
      m5 = model_state(5, since);
      e4 = m4[0:3];
      e5 = m5[0:4];
      checks++;
      if (cnt4 !== e4) begin
        failures++;
        $display("FAIL seq_w4 step=%0d got=%b exp=%b", since, cnt4, e4);
      end
      checks++;
      if (cnt5 !== e5) begin
        failures++;
        $display("FAIL seq_w5 step=%0d got=%b exp=%b", since, cnt5, e5);
      end
      if (prev_ok) begin
        checks++;
        if ($countones(prev4 ^ cnt4) != 1) begin
          failures++;
          $display("FAIL toggle_w4 prev=%b cur=%b exp_bits_changed=1", prev4, cnt4);
        end
        checks++;
        if ($countones(prev5 ^ cnt5) != 1) begin
          failures++;
          $display("FAIL toggle_w5 prev=%b cur=%b exp_bits_changed=1", prev5, cnt5);
        end
      end
      prev4   = cnt4;
      prev5   = cnt5;
      prev_ok = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
  end

  task automatic chk4(input string name, input logic [0:3] exp);
    checks++;
    if (cnt4 !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, cnt4, exp);
    end
  endtask

  task automatic chk5(input string name, input logic [0:4] exp);
    checks++;
    if (cnt5 !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, cnt5, exp);
    end
  endtask

  task automatic wait_since(input int n);
    int guard;
    guard = 0;
    while (since != n && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (since != n) begin
      failures++;
      $display("FAIL wait_step got=%0d exp=%0d", since, n);
    end
  endtask

  initial begin
    para[0] = 4'b0100; para[1] = 4'b1010; para[2] = 4'b1101; para[3] = 4'b0110;
    para[4] = 4'b1011; para[5] = 4'b0101; para[6] = 4'b0010; para[7] = 4'b1001;

    #10;
    reset = 1'b1;
    #1;
    chk4("async_reset_w4", 4'b0000);
    chk5("async_reset_w5", 5'b00000);
    #9;
    reset    = 1'b0;
    track_en = 1'b1;
    @(posedge clk);
    #1;
    chk4("first_w4", 4'b1000);
    chk5("first_w5", 5'b10000);

    wait_since(3);  chk4("step3_w4", 4'b1110);
    wait_since(4);  chk4("step4_w4", 4'b1111);
    wait_since(5);  chk5("step5_w5", 5'b11111);
    wait_since(7);  chk4("step7_w4", 4'b0001);
    wait_since(8);  chk4("wrap_w4", 4'b0000);
    wait_since(10); chk5("wrap_w5", 5'b00000);
    wait_since(19); chk4("step19_w4", 4'b1110);

    #3;
    track_en = 1'b0;
    reset    = 1'b1;
    #1;
    chk4("mid_reset_w4", 4'b0000);
    chk5("mid_reset_w5", 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk4("hold_reset_w4", 4'b0000);
      chk5("hold_reset_w5", 5'b00000);
    end
    reset    = 1'b0;
    track_en = 1'b1;
    @(posedge clk);
    #1;
    chk4("restart_w4", 4'b1000);
    wait_since(6); chk4("restart_step6_w4", 4'b0011);

    track_en = 1'b0;
    #2;
    force dut4.counter_q = 4'b0100;
    #1;
    release dut4.counter_q;
`ifdef JOHNSON_SELF_CORRECT_EN
    @(posedge clk);
    #1;
    chk4("self_correct_w4", 4'b0000);
    @(posedge clk);
    #1;
    chk4("self_correct_resume_w4", 4'b1000);
`else
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      chk4("parasitic_w4", para[(i + 1) % 8]);
    end
`endif

    reset = 1'b1;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
